// File: rtl/sudoku_board_writer_if.sv
// Write/response channel of the Sudoku board writer.
// The master drives requests; the slave (board store) answers with a one-cycle response pulse.
interface sudoku_board_writer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_index;
  logic [3:0] wr_digit;
  logic       wr_check;
  logic       wr_given;
  logic       resp_valid;
  logic       resp_ok;
  logic [6:0] resp_conflict;

  modport master (
    output wr_valid, wr_index, wr_digit, wr_check, wr_given,
    input  wr_ready, resp_valid, resp_ok, resp_conflict
  );

  modport slave (
    input  wr_valid, wr_index, wr_digit, wr_check, wr_given,
    output wr_ready, resp_valid, resp_ok, resp_conflict
  );
endinterface

// File: rtl/sudoku_board_writer.sv
// 9x9 Sudoku board store: handshake writes with optional duplicate scan, sequenced clear, display read port.
// Build option SUDOKU_GIVEN_LOCK_EN adds per-cell locks for puzzle givens.
module sudoku_board_writer #(
  parameter int CELLS = 81,
  parameter int DIM   = 9,
  parameter int BOX   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sudoku_board_writer_if.slave wr,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 board_full,
  input  logic [6:0]           rd_index,
  output logic [3:0]           rd_digit
);
  // state  | meaning
  // IDLE   | waiting for a write or a clear request
  // CHECK  | comparing cell j against the pending digit
  // COMMIT | write the cell unless rejected, pulse the response
  // CLEAR  | zeroing cell j and its lock
  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, CLEAR} state_t;

  localparam logic [6:0] LAST     = 7'(CELLS - 1);
  localparam logic [6:0] NONE     = 7'd127;
  localparam logic [6:0] DIM7     = 7'(DIM);
  localparam logic [3:0] DIM4     = 4'(DIM);
  localparam logic [3:0] DIM_LAST = 4'(DIM - 1);
  localparam logic [3:0] BOX4     = 4'(BOX);
  localparam logic [6:0] FULL     = 7'(CELLS);

  state_t     state, state_next;
  logic [3:0] cells [CELLS];
  logic [6:0] j, idx, conf_idx, fill_count, resp_conflict_q;
  logic [3:0] j_row, j_col, idx_row, idx_col, digit;
  logic       rej_bad, rej_lock, resp_ok_q;
  logic       accept, req_bad, req_lock, scan_hit, same_box, commit_ok;
  logic [6:0] commit_conf;

  assign req_bad = (wr.wr_index > LAST) || (wr.wr_digit > DIM4);

`ifdef SUDOKU_GIVEN_LOCK_EN
  logic [CELLS-1:0] lock;
  logic             given;
  assign req_lock = !req_bad && lock[wr.wr_index] && !wr.wr_given;
`else
  logic unused_given;
  assign unused_given = wr.wr_given;
  assign req_lock     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    wr.wr_ready = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        wr.wr_ready = rst_n && !clr_req;
        accept      = rst_n && !clr_req && wr.wr_valid;
        if (clr_req) begin
          state_next = CLEAR;
        end else if (accept) begin
          if (req_bad || req_lock || wr.wr_digit == 4'd0 || !wr.wr_check) state_next = COMMIT;
          else                                                            state_next = CHECK;
        end
      end
      CHECK:   if (j == LAST) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      CLEAR:   if (j == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Row/column counters track j so the scan needs no per-cycle division.
  always_ff @(posedge clk) begin
    if (!rst_n || !(state == CHECK || state == CLEAR)) begin
      j     <= 7'd0;
      j_row <= 4'd0;
      j_col <= 4'd0;
    end else begin
      j <= j + 7'd1;
      if (j_col == DIM_LAST) begin
        j_col <= 4'd0;
        j_row <= j_row + 4'd1;
      end else begin
        j_col <= j_col + 4'd1;
      end
    end
  end

  assign same_box  = (j_row / BOX4 == idx_row / BOX4) && (j_col / BOX4 == idx_col / BOX4);
  assign scan_hit  = (j != idx) && (cells[j] == digit) && ((j_row == idx_row) || (j_col == idx_col) || same_box);
  assign commit_ok = !rej_bad && !rej_lock && (conf_idx == NONE);
  assign commit_conf = rej_bad ? NONE : (rej_lock ? idx : conf_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) cells[i] <= 4'd0;
      idx             <= 7'd0;
      idx_row         <= 4'd0;
      idx_col         <= 4'd0;
      digit           <= 4'd0;
      rej_bad         <= 1'b0;
      rej_lock        <= 1'b0;
      conf_idx        <= NONE;
      fill_count      <= 7'd0;
      resp_ok_q       <= 1'b0;
      resp_conflict_q <= NONE;
`ifdef SUDOKU_GIVEN_LOCK_EN
      lock            <= '0;
      given           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          idx      <= wr.wr_index;
          idx_row  <= 4'(wr.wr_index / DIM7);
          idx_col  <= 4'(wr.wr_index % DIM7);
          digit    <= wr.wr_digit;
          rej_bad  <= req_bad;
          rej_lock <= req_lock;
          conf_idx <= NONE;
`ifdef SUDOKU_GIVEN_LOCK_EN
          given    <= wr.wr_given;
`endif
        end
        // Only the first hit is kept, so the reported conflict is the lowest index.
        CHECK: if (scan_hit && conf_idx == NONE) conf_idx <= j;
        COMMIT: begin
          resp_ok_q       <= commit_ok;
          resp_conflict_q <= commit_conf;
          if (commit_ok) begin
            cells[idx] <= digit;
            if (cells[idx] == 4'd0 && digit != 4'd0)      fill_count <= fill_count + 7'd1;
            else if (cells[idx] != 4'd0 && digit == 4'd0) fill_count <= fill_count - 7'd1;
`ifdef SUDOKU_GIVEN_LOCK_EN
            if (given) lock[idx] <= 1'b1;
`endif
          end
        end
        CLEAR: begin
          cells[j]   <= 4'd0;
          fill_count <= 7'd0;
`ifdef SUDOKU_GIVEN_LOCK_EN
          lock[j]    <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign wr.resp_valid    = (state == COMMIT);
  assign wr.resp_ok       = (state == COMMIT) ? commit_ok : resp_ok_q;
  assign wr.resp_conflict = (state == COMMIT) ? commit_conf : resp_conflict_q;
  assign busy             = (state != IDLE);
  assign board_full       = (fill_count == FULL);
  assign rd_digit         = (rd_index <= LAST) ? cells[rd_index] : 4'd0;
endmodule

// File: doc/sudoku_board_writer.md
Name: sudoku_board_writer

Overview:
- Owns the 9x9 Sudoku board store (81 cells x 4 bits) that the VGA number pixel generator reads for cell rendering.
- Accepts digit write and erase requests over a valid/ready handshake, from the recogniser or the keypad path.
- Optionally scans the row, column and 3x3 box for a duplicate digit before committing the write.
- Provides a sequenced whole-board clear and a combinational read port for the display.

Parameters:
- CELLS, 81, number of board cells; the index range is 0..CELLS-1.
- DIM, 9, board side length; cell index = row*DIM + col.
- BOX, 3, box side length; box id = (row/BOX, col/BOX).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  block can accept a write this cycle.
- wr_index  in  7  target cell, 0..80.
- wr_digit  in  4  0 = erase, 1..9 = digit.
- wr_check  in  1  1 = run the conflict scan before commit.
- wr_given  in  1  marks the cell as a puzzle given (used only with GIVEN_LOCK_EN).
- resp_valid  out  1  one-cycle response pulse.
- resp_ok  out  1  1 = write committed.
- resp_conflict  out  7  lowest conflicting index when rejected; 127 when there is no conflict or the request is invalid.
- clr_req  in  1  request a whole-board clear.
- busy  out  1  high in any state other than IDLE.
- board_full  out  1  all 81 cells are nonzero.
- rd_index  in  7  display read address.
- rd_digit  out  4  combinational cell contents; returns 0 if rd_index > 80.

Behaviour:
- Reset, sampled on clk while rst_n=0:
  - All cells 0 and all locks 0.
  - State IDLE.
  - wr_ready=0 during reset; resp_valid=0, resp_ok=0, resp_conflict=127, busy=0, board_full=0, fill count 0.
  - Reset mid-scan or mid-clear aborts the operation; no response is issued.
- States: IDLE, CHECK, COMMIT, CLEAR.
- wr_ready = (state==IDLE) && !clr_req. Clear takes priority over a simultaneous write; the write stays pending.
- Accept happens on wr_valid && wr_ready. The block latches index, digit, check and given.
- Transitions out of IDLE on accept:
  - wr_index>80 or wr_digit>9: go to COMMIT with the reject flag set and conflict=127.
  - wr_digit==0 or wr_check==0: go to COMMIT directly.
  - Otherwise go to CHECK with scan counter j=0.
- CHECK: one cell per cycle, j = 0..80, always 81 cycles, no early exit.
  - Conflict condition: j != idx && cell[j]==digit && (same row || same col || same box).
  - The first hit latches j as the conflict index; later hits are ignored.
  - After j=80, go to COMMIT.
- COMMIT: one cycle.
  - resp_valid=1 in this cycle.
  - If there is no reject, write the cell and set resp_ok=1.
  - The new value is visible on rd_digit from the next cycle.
  - Update the fill count: +1 for 0 to nonzero, -1 for nonzero to 0, unchanged otherwise. board_full = (count==81), registered.
  - Return to IDLE.
- Latency, with accept at cycle T:
  - Unchecked write: resp_valid at T+1.
  - Checked write: resp_valid at T+82.
- Writing the same digit over itself never conflicts with itself.
- CLEAR, entered from IDLE when clr_req=1:
  - Zeroes cell j and its lock for j = 0..80, one per cycle (81 cycles).
  - Fill count is 0 on exit; no resp_valid pulse; return to IDLE.
  - clr_req during CHECK or CLEAR is ignored, not queued.
- resp_ok and resp_conflict hold their values until the next COMMIT.

Optional Feature:
- Macro: SUDOKU_GIVEN_LOCK_EN.
- Defined:
  - An 81-bit lock array is kept.
  - A committed write with wr_given=1 sets lock[idx].
  - A write with wr_given=0 to a locked cell is rejected in COMMIT with no scan: resp_ok=0, resp_conflict=idx. Latency is T+1.
  - Locks clear only on reset or CLEAR.
- Not defined: wr_given is ignored, there is no lock storage, and every cell is writable.

Test Plan:
- Reset, then write idx 10, digit 5, check=0 -> resp_valid at T+1 with ok=1; rd_digit(10)=5 at T+2; board_full=0.
- Preload cell 12=7, then checked write idx 16, digit 7 (same row 1) -> resp at T+82, ok=0, conflict=12; cell 16 stays 0.
- Cells 0=4 and 20=4 (both in box 0), then checked write idx 10, digit 4 -> ok=0, conflict=0 (lowest index).
- Write idx 81 digit 3, then idx 5 digit 10 -> each gives ok=0, conflict=127 at T+1; board unchanged.
- Fill all 81 cells -> board_full=1. Then clr_req and wr_valid in the same cycle -> CLEAR runs first with busy high for 81 cycles; afterwards all cells 0, board_full=0, and the pending write is accepted after CLEAR.
- With SUDOKU_GIVEN_LOCK_EN: write idx 3 digit 2 given=1, then idx 3 digit 6 given=0 -> ok=0, conflict=3, cell stays 2. Without the macro the second write gives ok=1 and the cell becomes 6.
